// File: rtl/receiver.sv
// 8N1 UART receiver: synchronized rx, start-bit glitch filter, centre sampling,
// and single-cycle rx_valid / frame_err / overrun strobes toward an RX FIFO.
module receiver #(
  parameter int unsigned BAUD_DIV = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       fifo_full,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int unsigned H  = BAUD_DIV / 2;
  localparam int unsigned CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      idx;
  logic [7:0]      shift;
  logic            rx_m;
  logic            rx_s;

  // Two-flop synchronizer; idles high so reset looks like an idle line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Frame FSM with registered strobes; rx_busy tracks the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      rx_busy   <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state   <= START;
            cnt     <= '0;
            rx_busy <= 1'b1;
          end
        end
        START: begin
          if (cnt == CW'(H - 1)) begin
            cnt <= '0;
            if (!rx_s) begin
              state <= DATA;
              idx   <= '0;
            end else begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == CW'(BAUD_DIV - 1)) begin
            cnt        <= '0;
            shift[idx] <= rx_s;
            idx        <= idx + 3'd1;
            if (idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == CW'(BAUD_DIV - 1)) begin
            cnt <= '0;
            if (rx_s) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
              if (!fifo_full) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              state     <= WAIT_IDLE;
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_IDLE: begin
          // A held-low break stays here so it reports only one frame_err.
          if (rx_s) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_receiver.sv
// Scoreboard bench for receiver (BAUD_DIV=16): stimulus pushes expected strobes,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_receiver;

  localparam int unsigned BD = 16;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       fifo_full;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;

  typedef struct {
    logic [2:0] code;   // {overrun, frame_err, rx_valid}
    logic [7:0] data;
    int         cyc;    // expected observation cycle, 0 = unchecked
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  receiver #(.BAUD_DIV(BD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .fifo_full (fifo_full),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .rx_busy   (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  task automatic push(input logic [2:0] code, input logic [7:0] data, input int c);
    exp_t e;
    e.code = code;
    e.data = data;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BD) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
  endtask

  task automatic idle_cycles(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every strobe must be one-hot and match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && (rx_valid || frame_err || overrun)) begin
      chk("onehot", $countones({overrun, frame_err, rx_valid}), 1);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: got {ovr,ferr,vld}=%b expected none at cycle %0d",
                 {overrun, frame_err, rx_valid}, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("strobe_kind", int'({overrun, frame_err, rx_valid}), int'(e.code));
        chk("rx_data", int'(rx_data), int'(e.data));
        if (e.cyc != 0) chk("latency", cyc, e.cyc);
      end
    end
  end

  initial begin
    int s;
    rst_n     = 1'b0;
    rx        = 1'b1;
    fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rx_data", int'(rx_data), 8'h00);
    chk("rst_rx_valid", int'(rx_valid), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_rx_busy", int'(rx_busy), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cycles(5);

    // Good frame with latency: first low sample at edge s+1, strobe after edge s+1+154.
    s = cyc;
    push(3'b001, 8'hA5, s + 155);
    send_byte(8'hA5, 1'b1);
    idle_cycles(20);

    // Start-bit glitch must be rejected without any strobe.
    s = cyc;
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (s + 11 - cyc) @(posedge clk);
    @(negedge clk);
    chk("glitch_busy", int'(rx_busy), 0);
    idle_cycles(10);

    // Bad stop bit followed by a long break: exactly one frame_err.
    push(3'b010, 8'hA5, 0);
    send_byte(8'h3C, 1'b0);
    rx = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    idle_cycles(20);
    chk("busy_after_break", int'(rx_busy), 0);

    // FIFO full: overrun, data register keeps the previous byte.
    fifo_full = 1'b1;
    push(3'b100, 8'hA5, 0);
    send_byte(8'hFF, 1'b1);
    idle_cycles(10);
    fifo_full = 1'b0;
    chk("data_kept", int'(rx_data), 8'hA5);
    idle_cycles(10);

    // Back-to-back frames, no idle gap.
    push(3'b001, 8'h00, 0);
    push(3'b001, 8'h55, 0);
    push(3'b001, 8'h80, 0);
    send_byte(8'h00, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h80, 1'b1);
    idle_cycles(20);

    // Reset mid-DATA aborts 0x12 silently; 0x34 then received normally.
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midreset_rx_data", int'(rx_data), 8'h00);
    chk("midreset_busy", int'(rx_busy), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cycles(20);
    push(3'b001, 8'h34, 0);
    send_byte(8'h34, 1'b1);
    idle_cycles(50);

    chk("queue_empty", exp_q.size(), 0);
    chk("final_rx_data", int'(rx_data), 8'h34);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
